// File: rtl/ysyx_ifu.sv
// ysyx_ifu - instruction fetch unit
//
// Holds the fetch PC and issues one word read per instruction to instruction
// memory. The returned word and its PC are held for decode/execute behind a
// valid/ready handshake. A redirect from execute replaces the fetch PC and
// discards any in-flight or held wrong-path instruction.
//
// Ports
//   i_clk, i_rst                    clock, asynchronous active-high reset
//   i_redirect_valid/i_redirect_pc  PC change request from execute
//   o_imem_req_valid/_addr          fetch request (decoded from state only)
//   i_imem_req_ready                memory accepts the request this cycle
//   i_imem_resp_valid/_data         returned instruction word
//   o_inst_valid/o_inst/o_pc        fetched instruction and its PC
//   i_inst_ready                    downstream consumes the instruction
//   o_fetch_fault                   misaligned redirect target seen
//
// Build option: YSYX_IFU_MISALIGN_CHECK_EN
//   defined   - a misaligned redirect parks the unit in FAULT until an
//               aligned redirect arrives
//   undefined - redirect targets are forced word-aligned, o_fetch_fault = 0
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | just out of reset, moves to REQ on the next cycle
// REQ   | request for fetch_pc presented to memory
// WAIT  | request accepted, waiting for the response (drop = wrong path)
// HOLD  | instruction presented downstream until consumed or redirected
// FAULT | misaligned redirect target, no fetching until aligned redirect

module ysyx_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_resp_valid,
  input  logic [31:0] i_imem_resp_data,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_fetch_fault
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  logic [2:0]  r_state;
  logic [31:0] r_fetch_pc;
  logic        r_drop;
  logic        r_inst_valid;
  logic [31:0] r_inst;
  logic [31:0] r_pc;

  logic [31:0] w_redir_pc;
  logic        w_redir_bad;

`ifdef YSYX_IFU_MISALIGN_CHECK_EN
  logic r_fault;
  assign w_redir_pc    = i_redirect_pc;
  assign w_redir_bad   = |i_redirect_pc[1:0];
  assign o_fetch_fault = r_fault;
`else
  logic w_unused_redir_lsbs;
  assign w_unused_redir_lsbs = ^i_redirect_pc[1:0];
  assign w_redir_pc    = {i_redirect_pc[31:2], 2'b00};
  assign w_redir_bad   = 1'b0;
  assign o_fetch_fault = 1'b0;
`endif

  // Request side depends on registered state only.
  assign o_imem_req_valid = (r_state == S_REQ);
  assign o_imem_req_addr  = r_fetch_pc;
  assign o_inst_valid     = r_inst_valid;
  assign o_inst           = r_inst;
  assign o_pc             = r_pc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_fetch_pc   <= RESET_PC;
      r_drop       <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst       <= 32'h0;
      r_pc         <= RESET_PC;
`ifdef YSYX_IFU_MISALIGN_CHECK_EN
      r_fault      <= 1'b0;
`endif
    end else if (i_redirect_valid) begin
      r_fetch_pc   <= w_redir_pc;
      r_inst_valid <= 1'b0;
      r_state      <= w_redir_bad ? S_FAULT : S_REQ;
`ifdef YSYX_IFU_MISALIGN_CHECK_EN
      r_fault      <= w_redir_bad;
`endif
      case (r_state)
        S_REQ: begin
          // Old-address request goes out this cycle: its response is stale.
          if (i_imem_req_ready) begin
            r_drop <= 1'b1;
            if (!w_redir_bad) r_state <= S_WAIT;
          end else if (i_imem_resp_valid) begin
            r_drop <= 1'b0;
          end
        end
        S_WAIT: begin
          if (i_imem_resp_valid) begin
            r_drop <= 1'b0;
          end else begin
            r_drop <= 1'b1;
            if (!w_redir_bad) r_state <= S_WAIT;
          end
        end
        S_FAULT: begin
          if (i_imem_resp_valid) r_drop <= 1'b0;
        end
        default: ;
      endcase
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          // A response seen here can only be the stale one left pending
          // when a FAULT was exited, so it retires the drop.
          if (i_imem_resp_valid) r_drop <= 1'b0;
          if (i_imem_req_ready) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_imem_resp_valid) begin
            if (r_drop) begin
              r_drop  <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_inst       <= i_imem_resp_data;
              r_pc         <= r_fetch_pc;
              r_inst_valid <= 1'b1;
              r_state      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (i_inst_ready) begin
            r_inst_valid <= 1'b0;
            r_fetch_pc   <= r_fetch_pc + 32'd4;
            r_state      <= S_REQ;
          end
        end
        S_FAULT: begin
          if (i_imem_resp_valid) r_drop <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
